// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer with perf counters and LSU timeout flag
module pipe_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_rd_wren,
  input  logic             i_ex_mem_rd,
  input  logic             i_ex_mispred,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_wb_insn_vld,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_en,
  output logic             o_ex_mem_en,
  output logic             o_mem_wb_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_flush,
  output logic [1:0]       o_state,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_retire_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ACT_RUN     = 2'd0,
    ACT_LDUSE   = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_MEMWAIT = 2'd3
  } act_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       TO_LIM  = 8'(MEM_TIMEOUT);

  act_t             r_state;
  act_t             w_act;
  logic             w_freeze;
  logic             w_ldu;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic [7:0]       r_frz_cnt;
  logic [7:0]       w_frz_nxt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_freeze  = i_mem_req & ~i_mem_ready;
  assign w_rs1_hit = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
  assign w_ldu     = i_ex_mem_rd & i_ex_rd_wren & (i_ex_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // Saturating increment of the consecutive-freeze counter
  assign w_frz_nxt = (r_frz_cnt == 8'hFF) ? 8'hFF : r_frz_cnt + 8'd1;

  // Pick this cycle's action (freeze > mispredict > load-use > run); reset drains to bubbles
  always_comb begin
    w_act          = ACT_RUN;
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_id_ex_en     = 1'b1;
    o_ex_mem_en    = 1'b1;
    o_mem_wb_en    = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    if (w_freeze) begin
      w_act       = ACT_MEMWAIT;
      o_pc_en     = 1'b0;
      o_if_id_en  = 1'b0;
      o_id_ex_en  = 1'b0;
      o_ex_mem_en = 1'b0;
      o_mem_wb_en = 1'b0;
    end else if (i_ex_mispred) begin
      // Load-use on the wrong path is irrelevant; both younger stages are squashed
      w_act         = ACT_FLUSH;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (w_ldu) begin
      // One bubble into EX; forwarding supplies the load result next cycle
      w_act         = ACT_LDUSE;
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b0;
      o_id_ex_flush = 1'b1;
    end
    if (!i_reset) begin
      o_pc_en        = 1'b1;
      o_if_id_en     = 1'b1;
      o_id_ex_en     = 1'b1;
      o_ex_mem_en    = 1'b1;
      o_mem_wb_en    = 1'b1;
      o_if_id_flush  = 1'b1;
      o_id_ex_flush  = 1'b1;
      o_ex_mem_flush = 1'b1;
    end
  end

  // Record the action taken and track consecutive freezes for the sticky timeout
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ACT_RUN;
      r_frz_cnt     <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_act;
      if (w_freeze) begin
        r_frz_cnt <= w_frz_nxt;
        if (w_frz_nxt >= TO_LIM) begin
          r_mem_timeout <= 1'b1;
        end
      end else begin
        r_frz_cnt <= 8'd0;
      end
    end
  end

  // Performance counters, wrapping at 2^CNT_W
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if (i_wb_insn_vld & o_mem_wb_en) begin
        r_retire_cnt <= r_retire_cnt + CNT_ONE;
      end
      if ((w_act == ACT_MEMWAIT) || (w_act == ACT_LDUSE)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_act == ACT_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign o_state       = r_state;
  assign o_mem_timeout = r_mem_timeout;
  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_retire_cnt  = r_retire_cnt;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_FRZ = 8'b00000_000;
  localparam logic [7:0] C_MIS = 8'b11111_110;
  localparam logic [7:0] C_LDU = 8'b00111_010;
  localparam logic [7:0] C_RST = 8'b11111_111;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, wren, mrd, mis, mreq, mrdy, wb;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_fl, id_ex_fl, ex_mem_fl;
  logic [1:0]  st;
  logic        tmo;
  logic [31:0] cyc_cnt, ret_cnt, stl_cnt, fls_cnt;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic        to;
    logic        chk_cnt;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [31:0] stl;
    logic [31:0] fls;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    n_checks = 0;
  int    n_err    = 0;

  pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_used(u1), .i_id_rs2_used(u2),
    .i_ex_rd_addr(rd), .i_ex_rd_wren(wren), .i_ex_mem_rd(mrd),
    .i_ex_mispred(mis), .i_mem_req(mreq), .i_mem_ready(mrdy),
    .i_wb_insn_vld(wb),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_id_ex_en(id_ex_en),
    .o_ex_mem_en(ex_mem_en), .o_mem_wb_en(mem_wb_en),
    .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl), .o_ex_mem_flush(ex_mem_fl),
    .o_state(st), .o_mem_timeout(tmo),
    .o_cycle_cnt(cyc_cnt), .o_retire_cnt(ret_cnt),
    .o_stall_cnt(stl_cnt), .o_flush_cnt(fls_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic q, input logic y, input logic m,
                       input logic w, input logic lr, input logic we, input logic [4:0] d,
                       input logic [4:0] a1, input logic e1, input logic [4:0] a2, input logic e2);
    rst_n = r; mreq = q; mrdy = y; mis = m; wb = w;
    mrd = lr; wren = we; rd = d; rs1 = a1; u1 = e1; rs2 = a2; u2 = e2;
  endtask

  task automatic idle(input logic w);
    apply(1'b1, 1'b0, 1'b0, 1'b0, w, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic push(input string n, input logic [7:0] c, input logic [1:0] s, input logic t,
                      input logic k, input int cy, input int rt, input int sl, input int fl);
    exp_t e;
    e.ctrl = c; e.st = s; e.to = t; e.chk_cnt = k;
    e.cyc = 32'(cy); e.ret = 32'(rt); e.stl = 32'(sl); e.fls = 32'(fl);
    sb.push_back(e);
    sb_name.push_back(n);
  endtask

  task automatic expc(input string n, input logic [7:0] c, input logic [1:0] s, input logic t,
                      input int cy, input int rt, input int sl, input int fl);
    push(n, c, s, t, 1'b1, cy, rt, sl, fl);
  endtask

  // Monitor: pop one expectation per cycle and compare away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t        e;
      string       n;
      logic [7:0]  act;
      e   = sb.pop_front();
      n   = sb_name.pop_front();
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl};
      n_checks++;
      if (act !== e.ctrl) begin
        n_err++;
        $display("FAIL %s ctrl: got %b want %b", n, act, e.ctrl);
      end
      n_checks++;
      if (st !== e.st) begin
        n_err++;
        $display("FAIL %s state: got %0d want %0d", n, st, e.st);
      end
      n_checks++;
      if (tmo !== e.to) begin
        n_err++;
        $display("FAIL %s timeout: got %b want %b", n, tmo, e.to);
      end
      if (e.chk_cnt) begin
        n_checks++;
        if ({cyc_cnt, ret_cnt, stl_cnt, fls_cnt} !== {e.cyc, e.ret, e.stl, e.fls}) begin
          n_err++;
          $display("FAIL %s counters: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n,
                   cyc_cnt, ret_cnt, stl_cnt, fls_cnt, e.cyc, e.ret, e.stl, e.fls);
        end
      end
    end
  end

  initial begin
    logic [9:0] wbp;
    int         guard;
    wbp = 10'b1011011011;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);

    next_cycle(); apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("reset", C_RST, 2'd0, 1'b0, 0, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      next_cycle(); idle(wbp[i]);
      push("run10", C_RUN, 2'd0, 1'b0, 1'b0, 0, 0, 0, 0);
    end
    next_cycle(); apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("cnt_pre_rst", C_RST, 2'd0, 1'b0, 10, 7, 0, 0);
    next_cycle(); idle(1'b0);
    expc("cnt_post_rst", C_RUN, 2'd0, 1'b0, 0, 0, 0, 0);

    next_cycle(); apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd7, 1'b1);
    expc("ldu_rs1", C_LDU, 2'd0, 1'b0, 1, 0, 0, 0);
    next_cycle(); idle(1'b0);
    expc("ldu_after", C_RUN, 2'd1, 1'b0, 2, 0, 1, 0);
    next_cycle(); apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1);
    expc("ldu_x0", C_RUN, 2'd0, 1'b0, 3, 0, 1, 0);
    next_cycle(); apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    expc("ldu_rs2", C_LDU, 2'd0, 1'b0, 4, 0, 1, 0);
    next_cycle(); apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b0);
    expc("ldu_rs2_unused", C_RUN, 2'd1, 1'b0, 5, 0, 2, 0);

    next_cycle(); apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    expc("mis_ldu", C_MIS, 2'd0, 1'b0, 6, 0, 2, 0);
    next_cycle(); idle(1'b0);
    expc("mis_after", C_RUN, 2'd2, 1'b0, 7, 0, 2, 1);

    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("wait1", C_FRZ, 2'd0, 1'b0, 8, 0, 2, 1);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("wait2", C_FRZ, 2'd3, 1'b0, 9, 0, 3, 1);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("wait3", C_FRZ, 2'd3, 1'b0, 10, 0, 4, 1);
    next_cycle(); apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("wait_ready", C_RUN, 2'd3, 1'b0, 11, 0, 5, 1);

    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("frz_mis1", C_FRZ, 2'd0, 1'b0, 12, 0, 5, 1);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("frz_mis2", C_FRZ, 2'd3, 1'b0, 13, 0, 6, 1);
    next_cycle(); apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("frz_mis_rel", C_MIS, 2'd3, 1'b0, 14, 0, 7, 1);
    next_cycle(); idle(1'b0);
    expc("frz_mis_after", C_RUN, 2'd2, 1'b0, 15, 0, 7, 2);

    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to1", C_FRZ, 2'd0, 1'b0, 16, 0, 7, 2);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to2", C_FRZ, 2'd3, 1'b0, 17, 0, 8, 2);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to3", C_FRZ, 2'd3, 1'b0, 18, 0, 9, 2);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to4", C_FRZ, 2'd3, 1'b0, 19, 0, 10, 2);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to5", C_FRZ, 2'd3, 1'b1, 20, 0, 11, 2);
    next_cycle(); apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to6", C_FRZ, 2'd3, 1'b1, 21, 0, 12, 2);
    next_cycle(); apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("to_ready", C_RUN, 2'd3, 1'b1, 22, 0, 13, 2);
    next_cycle(); idle(1'b0);
    expc("to_sticky", C_RUN, 2'd0, 1'b1, 23, 1, 13, 2);
    next_cycle(); apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expc("rst_mid_frz", C_RST, 2'd0, 1'b1, 24, 1, 13, 2);
    next_cycle(); idle(1'b0);
    expc("rst_clears", C_RUN, 2'd0, 1'b0, 0, 0, 0, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
